match_pair_collector: RTL and testbench
=======================================

# match_pair_collector

Downstream stage of the matching top level. Consumes the per-frame stream of matched keypoint pairs (source/destination coordinates plus depth) and rejects pairs with zero depth or excessive pixel displacement. Buffers up to MAX_PAIRS accepted pairs per frame. After frame end, drains them to the pose-estimation stage over a ready/valid handshake and reports the pair count and an overflow flag.

## Interface
- MAX_PAIRS, 64: storage entries per frame (power of two, ≥2)
- MAX_DISP, 11'd64: max accepted L1 displacement |sx−dx|+|sy−dy|, in pixels
- CW = $clog2(MAX_PAIRS+1): count width (localparam)

- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_frame_start  in  1  one-cycle pulse, new frame from matcher
- i_frame_end  in  1  one-cycle pulse, matcher finished frame
- i_valid  in  1  matched pair present this cycle (no backpressure upstream)
- i_src_coor_x, i_src_coor_y, i_src_depth  in  10 each  previous-frame point
- i_dst_coor_x, i_dst_coor_y, i_dst_depth  in  10 each  current-frame point
- o_valid  out  1  pair presented downstream
- i_ready  in  1  downstream accepts when o_valid&i_ready
- o_src_coor_x, o_src_coor_y, o_src_depth, o_dst_coor_x, o_dst_coor_y, o_dst_depth  out  10 each  presented pair
- o_last  out  1  presented pair is final of frame
- o_pair_count  out  CW  accepted pairs in current/last frame
- o_overflow  out  1  sticky per frame: a passing pair was dropped
- o_frame_done  out  1  one-cycle pulse when frame fully delivered
- o_busy  out  1  high in COLLECT or DRAIN

## Operation
- FSM states IDLE, COLLECT, DRAIN; reset → IDLE.
- IDLE: pairs ignored. i_frame_start → COLLECT; clears count, wr/rd pointers, overflow.
- COLLECT: pair passes filter iff i_valid, src_depth≠0, dst_depth≠0, and L1 displacement ≤ MAX_DISP.
  - Displacement arithmetic: two 10-bit unsigned absolute differences summed into 11 bits, compared with MAX_DISP unsigned.
  - Passing pair with count<MAX_PAIRS: written at wr_ptr; count increments.
  - Passing pair with count==MAX_PAIRS: dropped; o_overflow set.
  - Failing pairs: silently discarded; no flag.
- COLLECT + i_frame_end:
  - A pair on the same cycle is evaluated and stored first.
  - Resulting count>0 → DRAIN.
  - Resulting count==0 → IDLE with o_frame_done pulse.
- COLLECT + i_frame_start (no end seen): restart — count, pointers and overflow cleared; same-cycle pair is evaluated into the new frame.
- DRAIN:
  - o_valid=1; outputs show entry rd_ptr; o_last=1 when rd_ptr==count−1.
  - On o_valid&i_ready, rd_ptr increments.
  - Accepting the last entry → o_frame_done pulse next cycle, then exit.
  - Incoming i_valid pairs are dropped; if passing, o_overflow sets.
  - i_frame_start sets a pending flag; on drain completion FSM enters COLLECT directly (frame init applied), else IDLE.
  - i_frame_end ignored.
- o_pair_count holds its value from frame end until the next frame init.

## Timing
- Reset values: o_valid, o_last, o_overflow, o_frame_done, o_busy = 0; o_pair_count = 0; all data outputs = 0.
- Storage write: 1 cycle after input; count visible on o_pair_count the following cycle.
- i_frame_end at cycle T → o_valid=1 at T+1 (DRAIN), showing entry 0.
- Downstream throughput: one pair per cycle with i_ready held high.
- Data outputs and o_last stay stable while o_valid&!i_ready; o_valid never drops before acceptance.
- o_frame_done: pulse at cycle after last handshake (or T+1 for an empty frame); o_valid=0 on that cycle.
- Reset asserted mid-DRAIN/COLLECT → immediately IDLE; outputs return to reset values; stored pairs discarded.

## Test plan
- Reset check: assert i_rst_n=0 mid-drain → all outputs 0 asynchronously; after release, FSM stays idle until next i_frame_start.
- Basic frame: start; pairs (100,100,50)->(110,105,52) and (200,50,30)->(190,60,31); end; i_ready=1 → two pairs on consecutive cycles, second with o_last=1, o_pair_count=2, o_frame_done one cycle later.
- Filter: pairs with src_depth=0, with dst_depth=0, with disp=65, with disp=64 → only the disp=64 pair stored, o_pair_count=1, o_overflow=0.
- Overflow: MAX_PAIRS+3 passing pairs → o_pair_count=MAX_PAIRS, o_overflow=1, exactly MAX_PAIRS drained in input order.
- Backpressure: i_ready toggled 1,0,0,1 during drain of 3 pairs → no entry skipped or duplicated; data stable while stalled.
- Boundaries:
  - Empty frame (start then end) → o_frame_done at T+1, o_valid never asserted.
  - Pair coincident with i_frame_end → included.
  - i_frame_start during drain → collection begins on the cycle after o_frame_done.

Source files
------------

// File: rtl/match_pair_collector.sv
// rtl/match_pair_collector.sv - filters matched keypoint pairs per frame, buffers them, drains downstream
module match_pair_collector #(
  parameter int          MAX_PAIRS = 64,
  parameter logic [10:0] MAX_DISP  = 11'd64,
  localparam int         CW        = $clog2(MAX_PAIRS + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_frame_start,
  input  logic          i_frame_end,
  input  logic          i_valid,
  input  logic [9:0]    i_src_coor_x,
  input  logic [9:0]    i_src_coor_y,
  input  logic [9:0]    i_src_depth,
  input  logic [9:0]    i_dst_coor_x,
  input  logic [9:0]    i_dst_coor_y,
  input  logic [9:0]    i_dst_depth,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [9:0]    o_src_coor_x,
  output logic [9:0]    o_src_coor_y,
  output logic [9:0]    o_src_depth,
  output logic [9:0]    o_dst_coor_x,
  output logic [9:0]    o_dst_coor_y,
  output logic [9:0]    o_dst_depth,
  output logic          o_last,
  output logic [CW-1:0] o_pair_count,
  output logic          o_overflow,
  output logic          o_frame_done,
  output logic          o_busy
);

  localparam int            AW      = $clog2(MAX_PAIRS);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PAIRS);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_q, rd_d;
  logic          ovf_q, ovf_d;
  logic          pend_q, pend_d;
  logic          drained_q, drained_d;
  logic          frame_done_q, frame_done_d;

  logic [59:0]   mem_q [MAX_PAIRS];
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] base_count;
  logic [9:0]    dx, dy;
  logic [10:0]   disp;
  logic          pass;
  logic [59:0]   rd_data;

  assign dx   = (i_src_coor_x >= i_dst_coor_x) ? i_src_coor_x - i_dst_coor_x : i_dst_coor_x - i_src_coor_x;
  assign dy   = (i_src_coor_y >= i_dst_coor_y) ? i_src_coor_y - i_dst_coor_y : i_dst_coor_y - i_src_coor_y;
  assign disp = {1'b0, dx} + {1'b0, dy};
  assign pass = i_valid && (i_src_depth != 10'd0) && (i_dst_depth != 10'd0) && (disp <= MAX_DISP);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    rd_d         = rd_q;
    ovf_d        = ovf_q;
    pend_d       = pend_q;
    drained_d    = drained_q;
    frame_done_d = 1'b0;
    wr_en        = 1'b0;
    base_count   = i_frame_start ? '0 : count_q;
    wr_addr      = base_count[AW-1:0];
    case (state_q)
      IDLE: begin
        if (i_frame_start) begin
          state_d = COLLECT;
          count_d = '0;
          rd_d    = '0;
          ovf_d   = 1'b0;
          pend_d  = 1'b0;
        end
      end
      COLLECT: begin
        // A restart clears the frame but still evaluates the same-cycle pair into it
        wr_en   = pass && (base_count < MAX_CNT);
        count_d = base_count + CW'(wr_en);
        ovf_d   = (ovf_q && !i_frame_start) || (pass && !(base_count < MAX_CNT));
        rd_d    = '0;
        if (!i_frame_start && i_frame_end) begin
          if (count_d != '0) begin
            state_d   = DRAIN;
            drained_d = 1'b0;
            pend_d    = 1'b0;
          end else begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (pass) ovf_d = 1'b1;
        if (i_frame_start) pend_d = 1'b1;
        if (drained_q) begin
          // Done pulse cycle: leave for the next frame or go idle
          drained_d = 1'b0;
          if (pend_q || i_frame_start) begin
            state_d = COLLECT;
            count_d = '0;
            rd_d    = '0;
            ovf_d   = 1'b0;
            pend_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (i_ready) begin
          rd_d = rd_q + AW'(1);
          if (o_last) begin
            drained_d    = 1'b1;
            frame_done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      rd_q         <= '0;
      ovf_q        <= 1'b0;
      pend_q       <= 1'b0;
      drained_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rd_q         <= rd_d;
      ovf_q        <= ovf_d;
      pend_q       <= pend_d;
      drained_q    <= drained_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_addr] <= {i_src_coor_x, i_src_coor_y, i_src_depth,
                                  i_dst_coor_x, i_dst_coor_y, i_dst_depth};
  end

  // Data is gated so outputs read zero whenever nothing is presented
  assign rd_data      = o_valid ? mem_q[rd_q] : '0;
  assign o_valid      = (state_q == DRAIN) && !drained_q;
  assign o_last       = o_valid && (CW'(rd_q) == count_q - CW'(1));
  assign o_src_coor_x = rd_data[59:50];
  assign o_src_coor_y = rd_data[49:40];
  assign o_src_depth  = rd_data[39:30];
  assign o_dst_coor_x = rd_data[29:20];
  assign o_dst_coor_y = rd_data[19:10];
  assign o_dst_depth  = rd_data[9:0];
  assign o_pair_count = count_q;
  assign o_overflow   = ovf_q;
  assign o_frame_done = frame_done_q;
  assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_match_pair_collector.sv
// tb/tb_match_pair_collector.sv - directed self-checking bench for match_pair_collector
module tb_match_pair_collector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_start, frame_end, valid, ready;
  logic [9:0] sx, sy, sd, dx, dy, dd;
  logic       o_valid, o_last, o_overflow, o_frame_done, o_busy;
  logic [9:0] o_sx, o_sy, o_sd, o_dx, o_dy, o_dd;
  logic [6:0] o_count;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  match_pair_collector dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_frame_start(frame_start), .i_frame_end(frame_end), .i_valid(valid),
    .i_src_coor_x(sx), .i_src_coor_y(sy), .i_src_depth(sd),
    .i_dst_coor_x(dx), .i_dst_coor_y(dy), .i_dst_depth(dd),
    .o_valid(o_valid), .i_ready(ready),
    .o_src_coor_x(o_sx), .o_src_coor_y(o_sy), .o_src_depth(o_sd),
    .o_dst_coor_x(o_dx), .o_dst_coor_y(o_dy), .o_dst_depth(o_dd),
    .o_last(o_last), .o_pair_count(o_count), .o_overflow(o_overflow),
    .o_frame_done(o_frame_done), .o_busy(o_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then drop the one-cycle pulses
  task automatic cyc();
    @(negedge clk);
    frame_start = 1'b0;
    frame_end   = 1'b0;
    valid       = 1'b0;
  endtask

  task automatic put(input int a, input int b, input int c, input int d, input int e, input int f);
    valid = 1'b1;
    sx = 10'(a); sy = 10'(b); sd = 10'(c);
    dx = 10'(d); dy = 10'(e); dd = 10'(f);
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; frame_end = 1'b0; valid = 1'b0; ready = 1'b1;
    sx = '0; sy = '0; sd = '0; dx = '0; dy = '0; dd = '0;
    repeat (3) cyc();
    check("rst_valid", o_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_count", o_count, 0);
    check("rst_done", o_frame_done, 0);
    check("rst_ovf", o_overflow, 0);
    check("rst_sx", o_sx, 0);
    rst_n = 1'b1;
    put(1, 1, 1, 1, 1, 1); cyc();
    check("idle_ignore_busy", o_busy, 0);
    check("idle_ignore_count", o_count, 0);

    // Basic two-pair frame
    frame_start = 1'b1; cyc();
    check("basic_busy", o_busy, 1);
    put(100, 100, 50, 110, 105, 52); cyc();
    check("basic_cnt1", o_count, 1);
    put(200, 50, 30, 190, 60, 31); cyc();
    check("basic_cnt2", o_count, 2);
    frame_end = 1'b1; cyc();
    check("basic_v0", o_valid, 1);
    check("basic_sx0", o_sx, 100);
    check("basic_sy0", o_sy, 100);
    check("basic_sd0", o_sd, 50);
    check("basic_dx0", o_dx, 110);
    check("basic_dy0", o_dy, 105);
    check("basic_dd0", o_dd, 52);
    check("basic_last0", o_last, 0);
    cyc();
    check("basic_v1", o_valid, 1);
    check("basic_sx1", o_sx, 200);
    check("basic_dd1", o_dd, 31);
    check("basic_last1", o_last, 1);
    check("basic_count", o_count, 2);
    cyc();
    check("basic_done", o_frame_done, 1);
    check("basic_done_valid", o_valid, 0);
    cyc();
    check("basic_done_clr", o_frame_done, 0);
    check("basic_idle", o_busy, 0);
    check("basic_count_hold", o_count, 2);

    // Filter; the disp=64 pair coincides with frame end
    frame_start = 1'b1; cyc();
    put(10, 10, 0, 10, 10, 5); cyc();
    put(10, 10, 5, 10, 10, 0); cyc();
    put(100, 100, 5, 140, 125, 5); cyc();
    put(0, 0, 1, 1023, 0, 1); cyc();
    put(100, 100, 5, 60, 124, 7); frame_end = 1'b1; cyc();
    check("filt_valid", o_valid, 1);
    check("filt_count", o_count, 1);
    check("filt_sx", o_sx, 100);
    check("filt_dx", o_dx, 60);
    check("filt_dy", o_dy, 124);
    check("filt_last", o_last, 1);
    check("filt_ovf", o_overflow, 0);
    cyc();
    check("filt_done", o_frame_done, 1);
    cyc();

    // Empty frame
    frame_start = 1'b1; cyc();
    check("empty_count_clr", o_count, 0);
    frame_end = 1'b1; cyc();
    check("empty_done", o_frame_done, 1);
    check("empty_valid", o_valid, 0);
    check("empty_busy", o_busy, 0);
    cyc();
    check("empty_done_clr", o_frame_done, 0);
    check("empty_valid2", o_valid, 0);

    // Restart in COLLECT keeps only the pair from the new frame
    frame_start = 1'b1; cyc();
    put(11, 11, 3, 11, 11, 3); cyc();
    put(22, 22, 3, 22, 22, 3); frame_start = 1'b1; cyc();
    check("restart_count", o_count, 1);
    frame_end = 1'b1; cyc();
    check("restart_sx", o_sx, 22);
    check("restart_last", o_last, 1);
    cyc();
    cyc();

    // Overflow
    frame_start = 1'b1; cyc();
    for (int i = 0; i < 67; i++) begin
      put(i, i, i + 1, i, i, 1); cyc();
    end
    check("ovf_flag", o_overflow, 1);
    check("ovf_count", o_count, 64);
    frame_end = 1'b1; cyc();
    for (int k = 0; k < 64; k++) begin
      check("ovf_drain_valid", o_valid, 1);
      check("ovf_drain_sx", o_sx, k);
      check("ovf_drain_sd", o_sd, k + 1);
      check("ovf_drain_last", o_last, (k == 63) ? 1 : 0);
      cyc();
    end
    check("ovf_done", o_frame_done, 1);
    check("ovf_done_valid", o_valid, 0);
    check("ovf_hold", o_overflow, 1);
    check("ovf_count_hold", o_count, 64);
    cyc();

    // Backpressure 1,0,0,1 with a frame start arriving mid-drain
    frame_start = 1'b1; cyc();
    put(301, 1, 9, 301, 1, 9); cyc();
    put(302, 2, 9, 302, 2, 9); cyc();
    put(303, 3, 9, 303, 3, 9); cyc();
    frame_end = 1'b1; cyc();
    check("bp_d0", o_sx, 301);
    ready = 1'b1; cyc();
    check("bp_d1", o_sx, 302);
    ready = 1'b0; cyc();
    check("bp_d2_sx", o_sx, 302);
    check("bp_d2_valid", o_valid, 1);
    check("bp_d2_last", o_last, 0);
    frame_start = 1'b1; cyc();
    check("bp_d3_sx", o_sx, 302);
    check("bp_d3_dy", o_dy, 2);
    ready = 1'b1; cyc();
    check("bp_d4_sx", o_sx, 303);
    check("bp_d4_last", o_last, 1);
    cyc();
    check("bp_done", o_frame_done, 1);
    check("bp_done_valid", o_valid, 0);
    put(5, 5, 5, 5, 5, 5); cyc();
    check("pend_busy", o_busy, 1);
    check("pend_count", o_count, 0);
    check("pend_ovf", o_overflow, 0);
    check("pend_valid", o_valid, 0);
    put(400, 7, 8, 401, 7, 8); cyc();
    check("pend_store", o_count, 1);
    frame_end = 1'b1; cyc();
    check("pend_sx", o_sx, 400);
    check("pend_last", o_last, 1);
    cyc();
    check("pend_done", o_frame_done, 1);
    cyc();

    // Asynchronous reset in the middle of a drain
    frame_start = 1'b1; cyc();
    put(50, 50, 4, 50, 50, 4); cyc();
    put(60, 60, 4, 60, 60, 4); cyc();
    ready = 1'b0; frame_end = 1'b1; cyc();
    check("mid_valid", o_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", o_valid, 0);
    check("arst_busy", o_busy, 0);
    check("arst_count", o_count, 0);
    check("arst_sx", o_sx, 0);
    check("arst_last", o_last, 0);
    @(negedge clk);
    rst_n = 1'b1; ready = 1'b1;
    cyc(); cyc();
    check("post_rst_busy", o_busy, 0);
    check("post_rst_valid", o_valid, 0);
    check("post_rst_done", o_frame_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
